// File: rtl/golden_epoch_ctrl.sv
// golden_epoch_ctrl: per-router golden-token sequencer. It scans {x,y,pktID} one step per epoch to keep routing livelock-free.
// Latency: outputs are registered and update one edge after the deciding cycle. No backpressure; freeze stalls the timer. Option: GOLDEN_EARLY_ADV_EN.
module golden_epoch_ctrl #(
    parameter int X_BITS      = 3,
    parameter int Y_BITS      = 3,
    parameter int PKTID_BITS  = 4,
    parameter int MESH_X      = 8,
    parameter int MESH_Y      = 8,
    parameter int GOLDEN_PKTS = 16,
    parameter int EPOCH_W     = 8,
    parameter int EPOCH_DEF   = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               freeze,
    input  logic                               cfg_we,
    input  logic [EPOCH_W-1:0]                 cfg_epoch_len,
    input  logic                               golden_done,
    output logic [X_BITS+Y_BITS+PKTID_BITS-1:0] counter_golden,
    output logic                               epoch_start,
    output logic                               round_wrap,
    output logic [EPOCH_W-1:0]                 epoch_remain
);

    localparam logic [X_BITS-1:0]     X_LAST   = X_BITS'(MESH_X - 1);
    localparam logic [Y_BITS-1:0]     Y_LAST   = Y_BITS'(MESH_Y - 1);
    localparam logic [PKTID_BITS-1:0] PKT_LAST = PKTID_BITS'(GOLDEN_PKTS - 1);
    localparam logic [EPOCH_W-1:0]    LEN_MIN  = EPOCH_W'(2);
    localparam logic [EPOCH_W-1:0]    LEN_DEF  = EPOCH_W'(EPOCH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctrlState_t;

    ctrlState_t              state;
    logic [X_BITS-1:0]       tokX;
    logic [Y_BITS-1:0]       tokY;
    logic [PKTID_BITS-1:0]   tokPkt;
    logic [EPOCH_W-1:0]      lenActive;
    logic [EPOCH_W-1:0]      lenPend;

    logic [EPOCH_W-1:0]      cfgLen;
    logic [EPOCH_W-1:0]      nextLen;
    logic                    earlyEnd;
    logic                    timerEnd;
    logic                    pktLast;
    logic                    yLast;
    logic                    xLast;

    // Lengths below 2 would make the end-of-epoch compare unreachable or degenerate.
    assign cfgLen  = (cfg_epoch_len < LEN_MIN) ? LEN_MIN : cfg_epoch_len;
    // A write landing on an epoch end is forwarded so the new epoch uses it at once.
    assign nextLen = cfg_we ? cfgLen : lenPend;

`ifdef GOLDEN_EARLY_ADV_EN
    assign earlyEnd = golden_done && ((lenActive - epoch_remain) >= LEN_MIN);
`else
    logic unusedGoldenDone;
    assign unusedGoldenDone = golden_done;
    assign earlyEnd         = 1'b0;
`endif

    assign timerEnd = (epoch_remain == EPOCH_W'(1)) || earlyEnd;
    assign pktLast  = (tokPkt == PKT_LAST);
    assign yLast    = (tokY == Y_LAST);
    assign xLast    = (tokX == X_LAST);

    assign counter_golden = {tokX, tokY, tokPkt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tokX         <= '0;
            tokY         <= '0;
            tokPkt       <= '0;
            lenActive    <= LEN_DEF;
            lenPend      <= LEN_DEF;
            epoch_remain <= LEN_DEF;
            epoch_start  <= 1'b0;
            round_wrap   <= 1'b0;
        end else begin
            epoch_start <= 1'b0;
            round_wrap  <= 1'b0;
            lenPend     <= nextLen;
            case (state)
                IDLE: begin
                    lenActive    <= nextLen;
                    epoch_remain <= nextLen;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (freeze) begin
                        state <= HOLD;
                    end else if (timerEnd) begin
                        // pktID is the fastest field, then Y, then X.
                        tokPkt <= pktLast ? '0 : tokPkt + PKTID_BITS'(1);
                        if (pktLast) begin
                            tokY <= yLast ? '0 : tokY + Y_BITS'(1);
                            if (yLast) begin
                                tokX <= xLast ? '0 : tokX + X_BITS'(1);
                            end
                        end
                        round_wrap   <= pktLast && yLast && xLast;
                        epoch_start  <= 1'b1;
                        lenActive    <= nextLen;
                        epoch_remain <= nextLen;
                    end else begin
                        epoch_remain <= epoch_remain - EPOCH_W'(1);
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!freeze) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tokenInRange: assert property (@(posedge clk) disable iff (reset)
        (tokX <= X_LAST) && (tokY <= Y_LAST) && (tokPkt <= PKT_LAST));
    remainNonZero: assert property (@(posedge clk) disable iff (reset)
        epoch_remain != '0);
    wrapWithStart: assert property (@(posedge clk) disable iff (reset)
        round_wrap |-> epoch_start);

endmodule

// File: tb/tb_golden_epoch_ctrl.sv
// Bench for golden_epoch_ctrl with default parameters (8x8 mesh, 16 pktIDs, 8-bit timer, 64-cycle default epoch).
module tb_golden_epoch_ctrl;

    localparam int MESH_X    = 8;
    localparam int MESH_Y    = 8;
    localparam int PKTS      = 16;
    localparam int EPOCH_DEF = 64;
    localparam int TOTAL     = MESH_X * MESH_Y * PKTS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       freeze = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_epoch_len = 8'd0;
    logic       golden_done = 1'b0;
    logic [9:0] counter_golden;
    logic       epoch_start;
    logic       round_wrap;
    logic [7:0] epoch_remain;

    golden_epoch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .freeze        (freeze),
        .cfg_we        (cfg_we),
        .cfg_epoch_len (cfg_epoch_len),
        .golden_done   (golden_done),
        .counter_golden(counter_golden),
        .epoch_start   (epoch_start),
        .round_wrap    (round_wrap),
        .epoch_remain  (epoch_remain)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tok;
        bit st;
        bit wr;
        int rem;
    } snap_t;

    typedef struct {
        int cyc;
        int tok;
        bit wr;
    } evt_t;

    snap_t snapQ[$];
    evt_t  evtQ[$];

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    // Reference: token is a linear index over the scan order; timer is dwell count in the epoch.
    int idx, lenAct, lenPend, dwell;
    bit active, held, mStart, mWrap;
    int modelWraps = 0;
    int dutWraps   = 0;
    bit resetDone  = 0;
    int postReset  = 0;

    function automatic int tokOf(input int i);
        return ((i / (MESH_Y * PKTS)) << 7) | (((i / PKTS) % MESH_Y) << 4) | (i % PKTS);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        idx     = 0;
        lenAct  = EPOCH_DEF;
        lenPend = EPOCH_DEF;
        dwell   = 0;
        active  = 0;
        held    = 0;
        mStart  = 0;
        mWrap   = 0;
    endtask

    task automatic pushSnap();
        snapQ.push_back('{tokOf(idx), mStart, mWrap, lenAct - dwell});
    endtask

    task automatic modelAdvance(input bit en, input bit frz, input bit we, input int len, input bit done);
        int newLen;
        bit early;
        newLen = we ? ((len < 2) ? 2 : len) : lenPend;
        early  = done && (dwell >= 2);
`ifndef GOLDEN_EARLY_ADV_EN
        early  = 0;
`endif
        mStart = 0;
        mWrap  = 0;
        if (!active) begin
            lenAct = newLen;
            dwell  = 0;
            active = en;
            held   = 0;
        end else if (!en) begin
            active = 0;
        end else if (held) begin
            held = frz;
        end else if (frz) begin
            held = 1;
        end else if (dwell == lenAct - 1 || early) begin
            idx    = (idx + 1) % TOTAL;
            mStart = 1;
            mWrap  = (idx == 0);
            lenAct = newLen;
            dwell  = 0;
            evtQ.push_back('{cyc + 1, tokOf(idx), mWrap});
            if (mWrap) modelWraps++;
        end else begin
            dwell++;
        end
        lenPend = newLen;
    endtask

    // Called just after an active edge; drives one cycle of inputs.
    task automatic step(input bit en, input bit frz, input bit we, input int len, input bit done);
        enable        = en;
        freeze        = frz;
        cfg_we        = we;
        cfg_epoch_len = 8'(len);
        golden_done   = done;
        modelAdvance(en, frz, we, len, done);
        @(posedge clk);
        #1;
        cyc++;
        pushSnap();
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        if (snapQ.size() > 0) void'(snapQ.pop_back());
        if (evtQ.size() > 0 && evtQ[$].cyc == cyc) begin
            if (evtQ[$].wr) modelWraps--;
            void'(evtQ.pop_back());
        end
        modelReset();
        chk("reset_token", int'(counter_golden), 0);
        chk("reset_epoch_start", int'(epoch_start), 0);
        chk("reset_round_wrap", int'(round_wrap), 0);
        chk("reset_epoch_remain", int'(epoch_remain), EPOCH_DEF);
        enable      = 1'b0;
        freeze      = 1'b0;
        cfg_we      = 1'b0;
        golden_done = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        pushSnap();
        reset = 1'b0;
    endtask

    initial begin
        snap_t s;
        evt_t  e;
        forever begin
            @(negedge clk);
            if (snapQ.size() > 0) begin
                s = snapQ.pop_front();
                chk("counter_golden", int'(counter_golden), s.tok);
                chk("epoch_start", int'(epoch_start), int'(s.st));
                chk("round_wrap", int'(round_wrap), int'(s.wr));
                chk("epoch_remain", int'(epoch_remain), s.rem);
            end
            if (epoch_start === 1'b1) begin
                if (round_wrap === 1'b1) dutWraps++;
                chk("epoch_event_pending", int'(evtQ.size() > 0), 1);
                if (evtQ.size() > 0) begin
                    e = evtQ.pop_front();
                    chk("epoch_event_cycle", cyc, e.cyc);
                    chk("epoch_event_token", int'(counter_golden), e.tok);
                    chk("epoch_event_wrap", int'(round_wrap), int'(e.wr));
                end
            end
        end
    end

    initial begin
        int len;
        modelReset();
        #1;
        doReset();

        // Four-cycle epochs from IDLE.
        step(0, 0, 1, 4, 0);
        repeat (20) step(1, 0, 0, 0, 0);

        // Shorten to the minimum mid-way through an 8-cycle epoch.
        step(1, 0, 1, 8, 0);
        for (int i = 0; i < 40 && !(mStart && lenAct == 8); i++) step(1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (12) step(1, 0, 0, 0, 0);

        // Freeze exactly on the last cycle of an epoch.
        step(1, 0, 1, 4, 0);
        for (int i = 0; i < 40 && !(lenAct == 4 && lenAct - dwell == 1); i++) step(1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0, 0);

        // Park, then resume.
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0, 0);

`ifdef GOLDEN_EARLY_ADV_EN
        step(1, 0, 1, 64, 0);
        for (int i = 0; i < 20 && !(mStart && lenAct == 64); i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 10 && dwell != 5; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0);
`endif

        // Random traffic through a full round, with one reset mid-run at token {3,5,7}.
        for (int n = 0; n < 50000; n++) begin
            if (modelWraps >= 1 && !resetDone && active && idx == 471) begin
                chk("token_before_reset", int'(counter_golden), tokOf(471));
                doReset();
                resetDone = 1;
            end
            if (resetDone) postReset++;
            if (postReset >= 300) break;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 5));
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 4, len, $urandom_range(0, 99) < 25);
        end

        @(negedge clk);
        #1;
        chk("reset_mid_run_reached", int'(resetDone), 1);
        chk("dut_round_wraps_seen", int'(dutWraps > 0), 1);
        chk("round_wrap_count", dutWraps, modelWraps);
        chk("epoch_events_drained", evtQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
